rd_burst_sequencer: RTL and testbench

- Upstream command stage for the single-read handshake controller.
- Accepts a burst command of N reads and issues one-cycle `start` pulses to the read controller, one read at a time.
- Waits for that controller's `ds` done strobe after each read, and counts completions.
- Aborts with an error if `ds` does not arrive within a timeout, then reports burst completion to the requester.

---
 rtl/rd_burst_sequencer.sv | 141 ++++++++++++++
 tb/tb_rd_burst_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_burst_sequencer.sv
// -----------------------------------------------------------------------------
// rd_burst_sequencer
//
// Upstream command stage for a single-read handshake controller. Accepts a
// burst command of cmd_len reads, issues one-cycle start pulses one read at a
// time, waits for the controller's ds done strobe after each read and counts
// completions. A read whose ds does not arrive within TMO WAIT cycles aborts
// the burst with an error. Completion is reported with a one-cycle xfer_done
// pulse, qualified by xfer_err.
//
// Ports:
//   clk        in   clock, all logic on rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   burst command offered
//   cmd_ready  out  sequencer can accept a command (IDLE)
//   cmd_len    in   number of reads in the burst (0 = empty burst)
//   start      out  one-cycle read request to the read controller
//   ds         in   one-cycle read-done strobe from the read controller
//   busy       out  burst in progress
//   xfer_done  out  one-cycle burst-complete pulse
//   xfer_err   out  error status, only meaningful (non-zero) with xfer_done
//   rd_cnt     out  reads completed in the current/last burst
//
// All outputs are decoded from registered state; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module rd_burst_sequencer #(
  parameter int LEN_W = 8,
  parameter int TMO   = 64,
  parameter int TMO_W = (TMO > 0) ? $clog2(TMO + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             start,
  input  logic             ds,
  output logic             busy,
  output logic             xfer_done,
  output logic             xfer_err,
  output logic [LEN_W-1:0] rd_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_END   = 2'd3
  } state_t;

  // Last timeout-counter value before abort; the counter starts at 0 in the
  // first WAIT cycle, so expiry happens on the TMO-th WAIT cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = (TMO > 0) ? TMO_W'(TMO - 1) : '0;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        // A ds seen here belongs to nobody and is dropped.
        if (cmd_valid) begin
          remain_d = cmd_len;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = (cmd_len == '0) ? S_END : S_ISSUE;
        end
      end

      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
        // No read is outstanding yet, so a ds here is a protocol error.
        if (ds) begin
          err_d = 1'b1;
        end
      end

      S_WAIT: begin
        // ds takes priority over an expiring timeout in the same cycle.
        if (ds) begin
          cnt_d    = cnt_q + LEN_W'(1);
          remain_d = remain_q - LEN_W'(1);
          state_d  = (remain_q == LEN_W'(1)) ? S_END : S_ISSUE;
        end else if (TMO != 0) begin
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_END;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end

      S_END: begin
        state_d = S_IDLE;
        if (ds) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign start     = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign xfer_done = (state_q == S_END);
  assign xfer_err  = (state_q == S_END) && err_q;
  assign rd_cnt    = cnt_q;

endmodule

// File: tb/tb_rd_burst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rd_burst_sequencer
//
// Bench for rd_burst_sequencer (TMO=8). A driver issues burst commands and
// plays the read controller (ds after a planned delay, or never). For each
// burst the expected start cycles and the expected completion (cycle,
// rd_cnt, xfer_err) are computed arithmetically from the burst plan and
// queued; a monitor on the falling edge pops and compares whenever the DUT
// shows start or xfer_done.
//
// Timing model (cycle c = interval after rising edge c):
//   accept seen in cycle a  -> first start (or done for len 0) in a+1
//   start in t, ds in t+d   -> next start / done in t+d+1
//   start in t, no ds       -> done in t+TMO+1 with error
// -----------------------------------------------------------------------------
module tb_rd_burst_sequencer;

  localparam int LEN_W = 8;
  localparam int TMO   = 8;
  localparam int BOUND = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             start;
  logic             ds;
  logic             busy;
  logic             xfer_done;
  logic             xfer_err;
  logic [LEN_W-1:0] rd_cnt;

  rd_burst_sequencer #(
    .LEN_W(LEN_W),
    .TMO  (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len  (cmd_len),
    .start    (start),
    .ds       (ds),
    .busy     (busy),
    .xfer_done(xfer_done),
    .xfer_err (xfer_err),
    .rd_cnt   (rd_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int done_cyc;
    int rd_cnt;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   exp_start_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  bit   done_prev = 1'b0;
  exp_t mon_e;

  // Burst plan: per-read ds delay (0 = never answer) and stray-ds read index.
  int plan_d [0:15];
  int plan_stray;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: no response within %0d cycles (cycle %0d)", name, BOUND, cyc);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (start) begin
        if (exp_start_q.size() == 0) begin
          bound_fail("unexpected_start");
        end else begin
          chk("start_cycle", cyc, exp_start_q.pop_front());
        end
      end
      if (xfer_done) begin
        if (exp_q.size() == 0) begin
          bound_fail("unexpected_done");
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_cycle", cyc, mon_e.done_cyc);
          chk("rd_cnt", rd_cnt, mon_e.rd_cnt);
          chk("xfer_err", xfer_err, mon_e.err);
          chk("starts_outstanding", exp_start_q.size(), 0);
        end
      end else begin
        chk("err_without_done", xfer_err, 0);
      end
      if (done_prev) chk("ready_after_done", cmd_ready, 1);
      chk("ready_vs_busy", cmd_ready, !busy);
    end
    done_prev = xfer_done;
  end

  task automatic run_burst(input int len);
    int   a, t, n;
    bit   err, seen;
    exp_t e;
    seen = 1'b0;
    for (int k = 0; k < BOUND && !seen; k++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1'b1;
    end
    if (!seen) begin
      bound_fail("cmd_ready_wait");
      return;
    end
    a         = cyc;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);

    // Reference model of the whole burst.
    t   = a + 1;
    n   = 0;
    err = 1'b0;
    e.done_cyc = a + 1;
    for (int i = 0; i < len; i++) begin
      exp_start_q.push_back(t);
      if (i == plan_stray) err = 1'b1;
      if (plan_d[i] == 0) begin
        err = 1'b1;
        e.done_cyc = t + TMO + 1;
        break;
      end
      n++;
      e.done_cyc = t + plan_d[i] + 1;
      t = e.done_cyc;
    end
    e.rd_cnt = n;
    e.err    = err;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_len   = LEN_W'($urandom);

    // Read-controller behaviour
    for (int i = 0; i < len; i++) begin
      seen = 1'b0;
      for (int k = 0; k < BOUND && !seen; k++) begin
        @(negedge clk);
        if (start) seen = 1'b1;
      end
      if (!seen) begin
        bound_fail("start_wait");
        return;
      end
      if (i == plan_stray) ds = 1'b1;
      @(posedge clk);
      #1;
      ds = 1'b0;
      if (plan_d[i] == 0) return;
      repeat (plan_d[i] - 1) @(posedge clk);
      #1;
      ds = 1'b1;
      @(posedge clk);
      #1;
      ds = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < BOUND && !seen; k++) begin
      @(negedge clk);
      if (cmd_ready && exp_q.size() == 0) seen = 1'b1;
    end
    if (!seen) bound_fail("idle_wait");
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    ds        = 1'b0;
    plan_stray = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", xfer_done, 0);
    chk("rst_err", xfer_err, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single read, ds 3 cycles after start
    plan_d[0] = 3; plan_stray = -1;
    run_burst(1);

    // Four reads with stretched ds delays
    plan_d[0] = 2; plan_d[1] = 5; plan_d[2] = 3; plan_d[3] = 2;
    run_burst(4);

    // Empty burst
    run_burst(0);

    // Timeout on the second read
    plan_d[0] = 4; plan_d[1] = 0; plan_d[2] = 2;
    run_burst(3);

    // ds on the last possible WAIT cycle wins over the timeout
    plan_d[0] = TMO; plan_d[1] = TMO;
    run_burst(2);

    // Stray ds during the first ISSUE
    plan_d[0] = 2; plan_d[1] = 3; plan_stray = 0;
    run_burst(2);
    plan_stray = -1;

    // Stray ds while idle: nothing changes (last burst left rd_cnt=2)
    wait_idle();
    ds = 1'b1;
    @(posedge clk);
    #1;
    ds = 1'b0;
    @(negedge clk);
    chk("idle_ds_rd_cnt", rd_cnt, 2);
    chk("idle_ds_busy", busy, 0);
    chk("idle_ds_ready", cmd_ready, 1);
    chk("idle_ds_start", start, 0);
    chk("idle_ds_done", xfer_done, 0);

    // Reset in WAIT of a 5-read burst after one completed read
    mon_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(5);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_first_start", start, 1);
    @(posedge clk);
    #1;
    ds = 1'b1;
    @(posedge clk);
    #1;
    ds = 1'b0;
    @(negedge clk);
    chk("rstmid_second_start", start, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_pre_rd_cnt", rd_cnt, 1);
    chk("rstmid_pre_busy", busy, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_start", start, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rd_cnt", rd_cnt, 0);
    chk("rstmid_ready", cmd_ready, 1);
    begin
      int dones;
      dones = 0;
      for (int k = 0; k < 4; k++) begin
        if (xfer_done) dones++;
        @(negedge clk);
      end
      chk("rstmid_no_done", dones, 0);
    end
    mon_en = 1'b1;
    plan_d[0] = 2; plan_d[1] = 1;
    run_burst(2);

    // Randomised bursts
    for (int b = 0; b < 25; b++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        plan_d[i] = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, TMO);
      end
      plan_stray = (len > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
      run_burst(len);
    end
    plan_stray = -1;

    wait_idle();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_start_q_drained", exp_start_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
